fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction ROM.
- Owns the PC and drives the ROM's `ce` and address; captures the instruction returned in the same cycle.
- Buffers {pc, inst} pairs in a small FIFO and presents them to the IF/ID decode boundary through a valid/ready handshake.
- Handles branch redirect with one MIPS delay slot, and exception flush redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value held during and immediately after reset.
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_o  out  32  fetch address to the ROM (ROM indexes `addr[..:2]`).
- ce_o  out  1  ROM chip enable; ROM outputs zero when low.
- inst_i  in  32  ROM read data; valid combinationally in the same cycle as `pc_o`.
- id_valid_o  out  1  FIFO head entry valid.
- id_pc_o  out  32  PC of the head entry.
- id_inst_o  out  32  instruction of the head entry.
- id_ready_i  in  1  decode accepts the head entry this cycle.
- branch_flag_i  in  1  decode resolved a taken branch/jump on the entry it accepts this cycle.
- branch_target_i  in  32  branch destination.
- flush_i  in  1  exception/eret flush.
- new_pc_i  in  32  exception handler or EPC address.
- occupancy_o  out  log2(DEPTH)+1  current FIFO count.

Behaviour:

Reset (rst=1 at an edge):
- `ce_o`=0, `pc_o`=RESET_PC, FIFO count=0.
- `id_valid_o`=0; `id_pc_o`/`id_inst_o`=0.
- `occupancy_o`=0.
- `ce_o` rises to 1 on the first edge with rst=0; `pc_o` is still RESET_PC that cycle.
- Reset asserted mid-operation discards all entries and overrides every other input.

Signal definitions:
- pop = `id_valid_o` & `id_ready_i`.
- push = `ce_o` & (count<DEPTH | pop), when neither flush nor branch applies.
- On push: write {`pc_o`, `inst_i`} at the tail; `pc_o` <= `pc_o`+4, wrapping modulo 2^32.
- Push and pop in the same cycle are legal, including when count=DEPTH; count is then unchanged.
- Full (count=DEPTH) with no pop: no push, `pc_o` holds, `ce_o` stays 1.
- Empty: `id_valid_o`=0.
- Output latency: an instruction fetched in cycle N is presented at the head in cycle N+1 at the earliest. There is no combinational path from `inst_i` to `id_*_o`.

Priority, highest first: rst > flush_i > branch > normal push/pop.

flush_i=1:
- FIFO count <= 0; no push.
- `pc_o` <= `new_pc_i`.
- `id_valid_o`=0 from the next cycle.
- `id_ready_i` and `branch_flag_i` are ignored this cycle.

Branch:
- Acts only when `branch_flag_i` & pop; `branch_flag_i` without pop is ignored.
- `pc_o` <= `branch_target_i`.
- The FIFO afterwards holds exactly one entry, the delay slot:
  - If count_after_pop ≥1: keep the new head, drop all younger entries, no push.
  - If count_after_pop =0: push the current {`pc_o`, `inst_i`} as the delay slot.
- `ce_o` is never deasserted after reset except by rst.
- `pc_o` is not required to be aligned; alignment faults are detected downstream.

Storage:
- Circular buffer with read/write pointers of log2(DEPTH) bits that wrap.
- Count is a separate register of log2(DEPTH)+1 bits.

Test Plan:
- Reset then release, `id_ready_i`=1 with ROM[0..3]=A0,A1,A2,A3 -> `ce_o` 0→1. `id_*` streams (0,A0),(4,A1),(8,A2), one per cycle, first valid 2 cycles after rst falls.
- `id_ready_i`=0 for 5 cycles from PC 0 -> `occupancy_o` reaches 2 and holds; `pc_o` stalls at 8. Raising ready drains (0,…),(4,…),(8,…) in order with no gaps or duplicates.
- Full FIFO (entries 0x10, 0x14), `pc_o`=0x18, pop with `branch_flag_i`=1, target 0x100 -> next head (0x14) kept as delay slot, occupancy=1, `pc_o`=0x100. Next outputs are 0x14 then 0x100.
- Empty FIFO: branch is popped the cycle its entry becomes the only entry, `pc_o`=0x24, target 0x200 -> 0x24 pushed as delay slot, `pc_o`=0x200.
- `flush_i`=1 with `new_pc_i`=0x380 while full and `branch_flag_i`=1 -> occupancy 0, `pc_o`=0x380, branch ignored. First post-flush output is (0x380, ROM[0xE0]).
- `pc_o`=0xFFFF_FFFC push -> next `pc_o`=0x0000_0000. rst pulsed mid-stream -> `id_valid_o`=0 and `pc_o`=RESET_PC the next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage in front of a combinational ROM.
// Owns the PC, captures {pc, inst} pairs into a small circular FIFO and
// presents the oldest pair to decode over a valid/ready handshake.
// Handles taken branches (one delay slot kept) and exception flushes.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic [31:0]               pc_o,
   output logic                      ce_o,
   input  logic [31:0]               inst_i,
   output logic                      id_valid_o,
   output logic [31:0]               id_pc_o,
   output logic [31:0]               id_inst_o,
   input  logic                      id_ready_i,
   input  logic                      branch_flag_i,
   input  logic [31:0]               branch_target_i,
   input  logic                      flush_i,
   input  logic [31:0]               new_pc_i,
   output logic [$clog2(DEPTH):0]    occupancy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Architectural state
   logic          ce_q,     ce_d;
   logic [31:0]   pc_q,     pc_d;
   logic [CW-1:0] count_q,  count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;

   // FIFO storage, one register pair per entry
   logic [31:0]   mem_pc_q   [DEPTH];
   logic [31:0]   mem_inst_q [DEPTH];

   // Write port into the FIFO (always writes the slot at wr_ptr_q)
   logic          mem_we;
   logic [31:0]   mem_wpc;
   logic [31:0]   mem_winst;

   logic          fifo_valid;
   logic          pop;
   logic          push;
   logic [AW-1:0] head_next;

   assign fifo_valid = (count_q != '0);
   assign pop        = fifo_valid & id_ready_i;
   assign head_next  = rd_ptr_q + AW'(1);

   // Next-state logic: flush beats branch, branch beats plain push/pop
   always_comb begin
      ce_d      = 1'b1;
      pc_d      = pc_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      mem_we    = 1'b0;
      mem_wpc   = pc_q;
      mem_winst = inst_i;
      push      = 1'b0;

      if (flush_i) begin
         // Drop everything and restart fetch at the handler / EPC
         pc_d     = new_pc_i;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else if (branch_flag_i && pop) begin
         // Taken branch retires with the popped entry; exactly one
         // delay-slot entry survives and fetch jumps to the target.
         pc_d     = branch_target_i;
         rd_ptr_d = head_next;
         if (count_q > CW'(1)) begin
            // Delay slot is already queued: keep it, discard younger ones
            count_d  = CW'(1);
            wr_ptr_d = head_next + AW'(1);
         end else if (ce_q) begin
            // Delay slot is being fetched right now: capture it
            mem_we   = 1'b1;
            count_d  = CW'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            count_d  = '0;
         end
      end else begin
         push = ce_q & ((count_q < DEPTH_C) | pop);
         if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            pc_d     = pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = head_next;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q     <= 1'b0;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         ce_q     <= ce_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Capture the fetched pair into this slot when it is the tail
         always_ff @(posedge clk) begin
            if (!rst && mem_we && (wr_ptr_q == AW'(gi))) begin
               mem_pc_q[gi]   <= mem_wpc;
               mem_inst_q[gi] <= mem_winst;
            end
         end
      end
   endgenerate

   assign pc_o        = pc_q;
   assign ce_o        = ce_q;
   assign occupancy_o = count_q;
   assign id_valid_o  = fifo_valid;
   // Head fields read zero when the queue is empty
   assign id_pc_o     = fifo_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
   assign id_inst_o   = fifo_valid ? mem_inst_q[rd_ptr_q] : 32'h0;

endmodule
